// File: rtl/pc_fetch_unit_if.sv
// Bundle of the fetch unit's branch, instruction-memory and decode-side handshakes.
// The master modport is the fetch unit; the slave modport is its surroundings.
interface pc_fetch_unit_if #(
    parameter int ADDR_W = 32
);
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ready;
    logic [31:0]       imem_rdata;
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] instr_pc;
    logic [ADDR_W-1:0] pc;

    modport master (
        input  branch_taken, branch_target, imem_ready, imem_rdata, instr_ready,
        output imem_req, imem_addr, instr_valid, instr, instr_pc, pc
    );

    modport slave (
        output branch_taken, branch_target, imem_ready, imem_rdata, instr_ready,
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, pc
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the PC, issues one outstanding word fetch at a time and hands
// tagged instructions to decode; branches discard stale fetch results.
module pc_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    pc_fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              valid_q, valid_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] ipc_q, ipc_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] rpc_q, rpc_d;
    logic [ADDR_W-1:0] target;

    assign target = bus.branch_target & ~ADDR_W'(3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= '0;
            ipc_q   <= '0;
            pend_q  <= 1'b0;
            rpc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            pend_q  <= pend_d;
            rpc_q   <= rpc_d;
        end
    end

    // A branch seen while the memory stalls is parked in rpc_q; the in-flight request
    // must still complete before the redirect can be issued.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req_d   = req_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        pend_d  = pend_q;
        rpc_d   = rpc_q;

        case (state_q)
            BOOT: begin
                state_d = FETCH;
                req_d   = 1'b1;
                if (bus.branch_taken) begin
                    pc_d   = target;
                    addr_d = target;
                end else begin
                    addr_d = pc_q;
                end
            end

            FETCH: begin
                if (bus.imem_ready) begin
                    if (bus.branch_taken) begin
                        pc_d   = target;
                        addr_d = target;
                        pend_d = 1'b0;
                    end else if (pend_q) begin
                        pc_d   = rpc_q;
                        addr_d = rpc_q;
                        pend_d = 1'b0;
                    end else begin
                        instr_d = bus.imem_rdata;
                        ipc_d   = addr_q;
                        valid_d = 1'b1;
                        pc_d    = pc_q + ADDR_W'(4);
                        req_d   = 1'b0;
                        state_d = HOLD;
                    end
                end else if (bus.branch_taken) begin
                    pend_d = 1'b1;
                    rpc_d  = target;
                end
            end

            HOLD: begin
                if (bus.branch_taken) begin
                    valid_d = 1'b0;
                    pc_d    = target;
                    addr_d  = target;
                    req_d   = 1'b1;
                    state_d = FETCH;
                end else if (bus.instr_ready) begin
                    valid_d = 1'b0;
                    addr_d  = pc_q;
                    req_d   = 1'b1;
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = addr_q;
    assign bus.instr_valid = valid_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = ipc_q;
    assign bus.pc          = pc_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: per-cycle vector table plus hand-written
// corner sequences, with a scoreboard of instructions expected at decode.
module tb_pc_fetch_unit;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    pc_fetch_unit_if #(.ADDR_W(32)) bus ();

    pc_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_1234;
    endfunction

    assign bus.imem_rdata = mem_word(bus.imem_addr);

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic        bt;
        logic [31:0] tgt;
        logic        mr;
        logic        ir;
        logic        push;
        logic [31:0] push_pc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_ipc;
        logic [31:0] e_pc;
    } row_t;

    row_t vec[14];

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic bt, input logic [31:0] tgt,
                                  input logic mr, input logic ir);
        bus.branch_taken  = bt;
        bus.branch_target = tgt;
        bus.imem_ready    = mr;
        bus.instr_ready   = ir;
    endtask

    task automatic push_expected(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.word = mem_word(pc);
        sb.push_back(e);
    endtask

    // Retire any decode handshake that the coming edge will complete, then advance.
    task automatic step();
        exp_t e;
        if (bus.instr_valid && bus.instr_ready) begin
            if (sb.size() == 0) begin
                check_output("unexpected_instr_pc", bus.instr_pc, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check_output("sb_instr_pc", bus.instr_pc, e.pc);
                check_output("sb_instr", bus.instr, e.word);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_fetch(input string tag, input logic req, input logic [31:0] addr,
                               input logic [31:0] pc);
        check_output({tag, "_req"}, {31'b0, bus.imem_req}, {31'b0, req});
        check_output({tag, "_addr"}, bus.imem_addr, addr);
        check_output({tag, "_pc"}, bus.pc, pc);
    endtask

    task automatic check_hold(input string tag, input logic [31:0] ipc, input logic [31:0] pc);
        check_output({tag, "_valid"}, {31'b0, bus.instr_valid}, 32'd1);
        check_output({tag, "_req"}, {31'b0, bus.imem_req}, 32'd0);
        check_output({tag, "_ipc"}, bus.instr_pc, ipc);
        check_output({tag, "_instr"}, bus.instr, mem_word(ipc));
        check_output({tag, "_pc"}, bus.pc, pc);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // boot, sequential fetch, stalled redirect, same-cycle redirect
        vec[0]  = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0,   32'h0};
        vec[1]  = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h0,   32'h4};
        vec[2]  = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h0,   1'b1, 32'h4,   1'b0, 32'h0,   32'h4};
        vec[3]  = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h4,   1'b1, 32'h4,   32'h8};
        vec[4]  = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h4,   1'b1, 32'h8,   1'b0, 32'h4,   32'h8};
        vec[5]  = '{1'b1, 32'h41,  1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   1'b0, 32'h4,   32'h8};
        vec[6]  = '{1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   1'b0, 32'h4,   32'h8};
        vec[7]  = '{1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   1'b0, 32'h4,   32'h8};
        vec[8]  = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h40,  1'b0, 32'h4,   32'h40};
        vec[9]  = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h40,  1'b1, 32'h40,  32'h44};
        vec[10] = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h40,  1'b1, 32'h44,  1'b0, 32'h40,  32'h44};
        vec[11] = '{1'b1, 32'h100, 1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h40,  32'h100};
        vec[12] = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h100, 1'b1, 32'h100, 32'h104};
        vec[13] = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h100, 1'b1, 32'h104, 1'b0, 32'h100, 32'h104};

        reset = 1'b1;
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_output("rst_req", {31'b0, bus.imem_req}, 32'd0);
        check_output("rst_addr", bus.imem_addr, 32'h0);
        check_output("rst_valid", {31'b0, bus.instr_valid}, 32'd0);
        check_output("rst_instr", bus.instr, 32'h0);
        check_output("rst_ipc", bus.instr_pc, 32'h0);
        check_output("rst_pc", bus.pc, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            apply_stimulus(vec[i].bt, vec[i].tgt, vec[i].mr, vec[i].ir);
            if (vec[i].push) push_expected(vec[i].push_pc);
            step();
            check_output($sformatf("vec%0d_req", i), {31'b0, bus.imem_req}, {31'b0, vec[i].e_req});
            check_output($sformatf("vec%0d_addr", i), bus.imem_addr, vec[i].e_addr);
            check_output($sformatf("vec%0d_valid", i), {31'b0, bus.instr_valid}, {31'b0, vec[i].e_valid});
            check_output($sformatf("vec%0d_ipc", i), bus.instr_pc, vec[i].e_ipc);
            check_output($sformatf("vec%0d_pc", i), bus.pc, vec[i].e_pc);
            if (vec[i].e_valid)
                check_output($sformatf("vec%0d_instr", i), bus.instr, mem_word(vec[i].e_ipc));
        end

        // decode stalls for five cycles on the instruction at 0x10
        apply_stimulus(1'b1, 32'h10, 1'b1, 1'b0);
        step();
        check_fetch("stall_redirect", 1'b1, 32'h10, 32'h10);
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
        step();
        for (int i = 0; i < 5; i++) begin
            check_hold($sformatf("stall%0d", i), 32'h10, 32'h14);
            step();
        end
        push_expected(32'h10);
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);
        step();
        check_fetch("stall_release", 1'b1, 32'h14, 32'h14);

        // unaligned target to the top word, then wrap to zero
        apply_stimulus(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        step();
        check_fetch("wrap_fetch", 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
        step();
        check_hold("wrap_hold", 32'hFFFF_FFFC, 32'h0);
        push_expected(32'hFFFF_FFFC);
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);
        step();
        check_fetch("wrap_next", 1'b1, 32'h0, 32'h0);

        // branch together with decode accept: instruction consumed and redirect taken
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
        step();
        push_expected(32'h0);
        apply_stimulus(1'b1, 32'h200, 1'b0, 1'b1);
        step();
        check_fetch("hold_br_ack", 1'b1, 32'h200, 32'h200);
        check_output("hold_br_ack_valid", {31'b0, bus.instr_valid}, 32'd0);

        // branch in HOLD without accept: held instruction dropped
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
        step();
        apply_stimulus(1'b1, 32'h300, 1'b0, 1'b0);
        step();
        check_fetch("hold_br_drop", 1'b1, 32'h300, 32'h300);
        check_output("hold_br_drop_valid", {31'b0, bus.instr_valid}, 32'd0);

        // two branches while stalled: the newer target wins
        apply_stimulus(1'b1, 32'h400, 1'b0, 1'b0);
        step();
        apply_stimulus(1'b1, 32'h500, 1'b0, 1'b0);
        step();
        check_fetch("double_br_wait", 1'b1, 32'h300, 32'h300);
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
        step();
        check_fetch("double_br_go", 1'b1, 32'h500, 32'h500);
        check_output("double_br_valid", {31'b0, bus.instr_valid}, 32'd0);
        step();
        check_hold("double_br_hold", 32'h500, 32'h504);
        push_expected(32'h500);
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);
        step();

        // reset asserted mid-request at 0x20 takes effect without a clock edge
        apply_stimulus(1'b1, 32'h20, 1'b1, 1'b0);
        step();
        check_fetch("midrst_pre", 1'b1, 32'h20, 32'h20);
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check_fetch("midrst_async", 1'b0, 32'h0, 32'h0);
        check_output("midrst_valid", {31'b0, bus.instr_valid}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
        step();
        check_fetch("midrst_first", 1'b1, 32'h0, 32'h0);
        step();
        check_hold("midrst_hold", 32'h0, 32'h4);
        push_expected(32'h0);
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);
        step();

        // branch during BOOT redirects the very first fetch
        reset = 1'b1;
        step();
        reset = 1'b0;
        apply_stimulus(1'b1, 32'h82, 1'b0, 1'b0);
        step();
        check_fetch("boot_br", 1'b1, 32'h80, 32'h80);
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
        step();
        check_hold("boot_br_hold", 32'h80, 32'h84);
        push_expected(32'h80);
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);
        step();

        check_output("sb_leftover", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
